sobel_frame_ctrl: RTL and testbench



---
 rtl/sobel_frame_ctrl.sv | 116 +++++++++++
 tb/tb_sobel_frame_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: validates a start configuration and admits one frame of pixels tagged with col/row and position flags.
// Optional stall watchdog is built when SOBEL_FRAME_TIMEOUT_EN is defined.
module sobel_frame_ctrl #(
   parameter int PIX_W       = 8,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [10:0]      img_width,
   input  logic [10:0]      img_height,
   input  logic [20:0]      total_pixel,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_data,
   output logic [10:0]      out_col,
   output logic [10:0]      out_row,
   output logic             out_sof,
   output logic             out_eol,
   output logic             out_eof,
   output logic             out_border,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic             timeout
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t      r_state;
   logic [10:0] r_w, r_h, r_col, r_row;
   logic [20:0] r_t, r_cnt;
   logic [21:0] w_prod;
   logic        w_cfg_ok, w_in_hs, w_out_hs, w_last_col, w_wd_fire;
   assign w_prod     = 22'(img_width) * 22'(img_height);
   assign w_cfg_ok   = img_width >= 11'd3 && img_height >= 11'd3 && w_prod == {1'b0, total_pixel};
   assign in_ready   = r_state == RUN && (!out_valid || out_ready) && r_cnt < r_t;
   assign w_in_hs    = in_valid && in_ready;
   assign w_out_hs   = out_valid && out_ready;
   assign w_last_col = r_col == r_w - 11'd1;
   assign busy       = r_state != IDLE;
`ifdef SOBEL_FRAME_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] r_wd;
   // Counts consecutive stalled RUN cycles while pixels are still owed.
   assign w_wd_fire = r_state == RUN && !w_in_hs && r_cnt < r_t && r_wd == WD_W'(TIMEOUT_CYC - 1);
   always_ff @(posedge clk) begin
      if (reset || r_state != RUN || w_in_hs || r_cnt >= r_t) r_wd <= '0;
      else r_wd <= r_wd + 1'b1;
      timeout <= !reset && w_wd_fire;
   end
`else
   assign w_wd_fire = 1'b0;
   assign timeout   = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_w        <= '0;
         r_h        <= '0;
         r_t        <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_cnt      <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_col    <= '0;
         out_row    <= '0;
         out_sof    <= 1'b0;
         out_eol    <= 1'b0;
         out_eof    <= 1'b0;
         out_border <= 1'b0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         case (r_state)
            IDLE: if (start) begin
               r_w     <= img_width;
               r_h     <= img_height;
               r_t     <= total_pixel;
               r_col   <= '0;
               r_row   <= '0;
               r_cnt   <= '0;
               r_state <= w_cfg_ok ? RUN : IDLE;
               cfg_err <= !w_cfg_ok;
            end
            RUN: begin
               if (w_wd_fire) begin
                  out_valid <= 1'b0;
                  r_state   <= IDLE;
               end else if (w_in_hs) begin
                  out_valid  <= 1'b1;
                  out_data   <= in_data;
                  out_col    <= r_col;
                  out_row    <= r_row;
                  out_sof    <= r_cnt == '0;
                  out_eol    <= w_last_col;
                  out_eof    <= r_cnt == r_t - 21'd1;
                  out_border <= r_row == '0 || r_row == r_h - 11'd1 || r_col == '0 || w_last_col;
                  r_col      <= w_last_col ? '0 : r_col + 11'd1;
                  r_row      <= w_last_col ? r_row + 11'd1 : r_row;
                  r_cnt      <= r_cnt + 21'd1;
               end else if (w_out_hs) out_valid <= 1'b0;
               if (w_out_hs && out_eof) begin
                  r_state <= DONE;
                  done    <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: scoreboard bench for sobel_frame_ctrl.
// Watchdog scenario runs only when SOBEL_FRAME_TIMEOUT_EN is defined.
module tb_sobel_frame_ctrl;
   localparam int PIX_W = 8;
   logic             clk = 1'b0;
   logic             reset, start, in_valid, in_ready, out_valid, out_ready;
   logic [10:0]      img_width, img_height, out_col, out_row;
   logic [20:0]      total_pixel;
   logic [PIX_W-1:0] in_data, out_data;
   logic             out_sof, out_eol, out_eof, out_border, busy, done, cfg_err, timeout;
   int               total = 0, bad = 0;
   int               m_w = 3, m_h = 3, m_idx = 0;
   int               beats = 0, cyc = 0, eof_cyc = -10, done_cyc = 0, dones = 0, tos = 0;
   logic             bp_en = 1'b0;
   logic [33:0]      q[$];
   always #5 clk = ~clk;
   sobel_frame_ctrl #(.PIX_W(PIX_W), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .reset(reset), .start(start), .img_width(img_width), .img_height(img_height),
      .total_pixel(total_pixel), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_col(out_col),
      .out_row(out_row), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
      .out_border(out_border), .busy(busy), .done(done), .cfg_err(cfg_err), .timeout(timeout)
   );
   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [33:0] exp_beat(int idx, logic [7:0] d);
      int c, r;
      c = idx % m_w;
      r = idx / m_w;
      return {d, 11'(c), 11'(r), idx == 0, c == m_w - 1, idx == m_w * m_h - 1,
              (r == 0 || r == m_h - 1 || c == 0 || c == m_w - 1)};
   endfunction
   // Scoreboard: push on input handshake, compare every valid output cycle, pop on output handshake.
   always @(negedge clk) begin
      cyc++;
      if (reset) q.delete();
      else begin
         if (out_valid) begin
            check("q_has_beat", 64'(q.size() != 0), 1);
            if (q.size() != 0) begin
               check("beat", {out_data, out_col, out_row, out_sof, out_eol, out_eof, out_border}, q[0]);
               if (out_ready) begin
                  void'(q.pop_front());
                  beats++;
                  if (out_eof) eof_cyc = cyc;
               end
            end
         end
         if (done) begin
            dones++;
            done_cyc = cyc;
         end
         if (timeout) tos++;
         if (in_valid && in_ready) begin
            q.push_back(exp_beat(m_idx, in_data));
            m_idx++;
         end
      end
   end
   initial begin
      int ph = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = bp_en ? (ph == 0 || ph == 3) : 1'b1;
         ph = (ph + 1) % 4;
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_start(int w, int h, int t);
      start = 1'b1;
      img_width = 11'(w);
      img_height = 11'(h);
      total_pixel = 21'(t);
      m_w = w;
      m_h = h;
      m_idx = 0;
      tick();
      start = 1'b0;
      img_width = 11'($urandom);
      img_height = 11'($urandom);
      total_pixel = 21'($urandom);
   endtask
   task automatic send(int n, int base);
      for (int i = 0; i < n; i++) begin
         int k = 0;
         in_valid = 1'b1;
         in_data = 8'(base + i);
         @(negedge clk);
         while (!in_ready && k < 100) begin
            k++;
            @(negedge clk);
         end
         if (k >= 100) check("send_stall", 64'(k), 0);
         tick();
      end
      in_valid = 1'b0;
   endtask
   task automatic wait_done(string tag, int b0, int nb);
      int d0 = dones;
      for (int i = 0; i < 200 && dones == d0; i++) tick();
      check({tag, "_done"}, 64'(dones - d0), 1);
      check({tag, "_done_lat"}, 64'(done_cyc), 64'(eof_cyc + 1));
      check({tag, "_beats"}, 64'(beats - b0), 64'(nb));
      check({tag, "_q_empty"}, 64'(q.size()), 0);
      check({tag, "_busy_off"}, 64'(busy), 0);
   endtask
   task automatic check_all_zero(string tag);
      check(tag, {in_ready, out_valid, out_data, out_col, out_row, out_sof, out_eol, out_eof,
                  out_border, busy, done, cfg_err, timeout}, 0);
   endtask
   initial begin
      int b0;
      reset = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      img_width = '0;
      img_height = '0;
      total_pixel = '0;
      repeat (3) tick();
      check_all_zero("reset_state");
      reset = 1'b0;
      tick();
      check_all_zero("post_reset_idle");
      // basic 4x3 frame
      b0 = beats;
      do_start(4, 3, 12);
      check("basic_busy", 64'(busy), 1);
      check("basic_cfg_err", 64'(cfg_err), 0);
      send(12, 0);
      wait_done("basic", b0, 12);
      // bad configurations
      do_start(4, 3, 11);
      check("bad1_cfg_err", 64'(cfg_err), 1);
      check("bad1_busy", 64'(busy), 0);
      check("bad1_in_ready", 64'(in_ready), 0);
      tick();
      check("bad1_err_pulse", 64'(cfg_err), 0);
      do_start(2, 5, 10);
      check("bad2_cfg_err", 64'(cfg_err), 1);
      check("bad2_busy", 64'(busy), 0);
      check("bad2_in_ready", 64'(in_ready), 0);
      tick();
      check("bad2_err_pulse", 64'(cfg_err), 0);
      // backpressure 3x3
      b0 = beats;
      bp_en = 1'b1;
      do_start(3, 3, 9);
      send(9, 100);
      wait_done("bp", b0, 9);
      bp_en = 1'b0;
      // start while busy is ignored
      b0 = beats;
      do_start(3, 3, 9);
      send(4, 50);
      start = 1'b1;
      img_width = 11'd5;
      img_height = 11'd5;
      total_pixel = 21'd25;
      tick();
      start = 1'b0;
      check("busy_start_busy", 64'(busy), 1);
      send(5, 54);
      wait_done("busy_start", b0, 9);
      repeat (3) tick();
      check("busy_start_no_restart", 64'(busy), 0);
      // reset mid-frame
      do_start(3, 3, 9);
      send(4, 200);
      reset = 1'b1;
      tick();
      check_all_zero("mid_reset");
      reset = 1'b0;
      b0 = beats;
      do_start(3, 3, 9);
      send(9, 30);
      wait_done("after_reset", b0, 9);
`ifdef SOBEL_FRAME_TIMEOUT_EN
      begin
         int d0 = dones;
         int t0 = tos;
         b0 = beats;
         do_start(3, 3, 9);
         send(2, 70);
         for (int i = 0; i < 40 && tos == t0; i++) tick();
         check("wd_timeout", 64'(tos - t0), 1);
         tick();
         check("wd_busy_off", 64'(busy), 0);
         check("wd_no_done", 64'(dones - d0), 0);
         check("wd_beats", 64'(beats - b0), 2);
         q.delete();
      end
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end
endmodule
